// File: rtl/ftoi.sv
// ftoi: IEEE-754 single-precision to signed 32-bit integer conversion.
// Two-stage pipeline: S1 classifies the operand and aligns the mantissa so the
// binary point sits above a {half, sticky} pair; S2 rounds (nearest, ties away
// from zero), applies the sign and saturates out-of-range values.
// A stall freezes both stages; reset clears every register and wins over stall.
module ftoi (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op,
  input  logic        valid_in,
  input  logic        stall,
  output logic [31:0] result,
  output logic        valid_out,
  output logic        ovf
);

  localparam int DATA_W  = 32;
  localparam int MAG_W   = 31;
  localparam int MANT_W  = 24;
  localparam int ALIGN_W = MAG_W + MANT_W;

  // ZERO: |op| < 0.5 rounds to 0; NORM: in range; SAT: too large;
  // MIN: exactly -2^31, representable although its magnitude needs 32 bits.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_SAT  = 2'd2,
    CLS_MIN  = 2'd3
  } cls_t;

  logic                    sign_in;
  logic [7:0]              exp_in;
  logic [MANT_W-1:0]       mant_in;
  logic [ALIGN_W-1:0]      aligned_in;
  logic [MAG_W+1:0]        mag_in;
  cls_t                    cls_in;

  logic                    vld_p1;
  logic                    sign_p1;
  cls_t                    cls_p1;
  logic [MAG_W+1:0]        mag_p1;

  logic [DATA_W:0]         out_p2;

  // Rounding: the half bit decides; the sticky bit only distinguishes an exact
  // tie from "above half", and both round the magnitude up (ties away from 0).
  function automatic logic [DATA_W-1:0] round_mag(input logic [MAG_W+1:0] a);
    logic half;
    logic sticky;
    logic tie;
    logic above;
    logic up;
    half   = a[1];
    sticky = a[0];
    tie    = half & ~sticky;
    above  = half & sticky;
    up     = tie | above;
    return {1'b0, a[MAG_W+1:2]} + {{(DATA_W-1){1'b0}}, up};
  endfunction

  // Saturation and sign application; returns {ovf, result}.
  function automatic logic [DATA_W:0] saturate(input cls_t c, input logic s,
                                               input logic [DATA_W-1:0] mag);
    logic signed [DATA_W-1:0] smag;
    logic signed [DATA_W-1:0] sres;
    logic                     o;
    smag = signed'(mag);
    sres = '0;
    o    = 1'b0;
    case (c)
      CLS_ZERO: begin
        sres = '0;
        o    = 1'b0;
      end
      CLS_NORM: begin
        sres = s ? -smag : smag;
        o    = 1'b0;
      end
      CLS_SAT: begin
        sres = s ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        o    = 1'b1;
      end
      default: begin
        sres = 32'sh8000_0000;
        o    = 1'b0;
      end
    endcase
    return {o, sres};
  endfunction

  // Operand decode, alignment and classification feeding S1.
  always_comb begin
    sign_in = op[31];
    exp_in  = op[30:23];
    mant_in = {1'b1, op[22:0]};
    // Shift by exp-126 = E+1 so the integer part lands in the top 31 bits and
    // the first fractional bit (half) sits directly below it.
    aligned_in = {{MAG_W{1'b0}}, mant_in} << (exp_in - 8'd126);
    mag_in     = {aligned_in[ALIGN_W-1:MANT_W], aligned_in[MANT_W-1],
                  |aligned_in[MANT_W-2:0]};
    if (exp_in < 8'd126) begin
      cls_in = CLS_ZERO;
    end else if (op == 32'hCF00_0000) begin
      cls_in = CLS_MIN;
    end else if (exp_in >= 8'd158) begin
      cls_in = CLS_SAT;
    end else begin
      cls_in = CLS_NORM;
    end
  end

  // ---- S1: sign, class and aligned magnitude ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      cls_p1  <= CLS_ZERO;
      mag_p1  <= '0;
    end else if (!stall) begin
      vld_p1  <= valid_in;
      sign_p1 <= sign_in;
      cls_p1  <= cls_in;
      mag_p1  <= mag_in;
    end
  end

  // Round, sign and saturate the S1 contents (also on bubbles, so the
  // registered outputs never carry X).
  always_comb begin
    out_p2 = saturate(cls_p1, sign_p1, round_mag(mag_p1));
  end

  // ---- S2: registered result, ovf and valid ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      valid_out <= vld_p1;
      result    <= out_p2[DATA_W-1:0];
      ovf       <= out_p2[DATA_W];
    end
  end

endmodule

// File: tb/tb_ftoi.sv
// tb_ftoi: self-checking bench for ftoi. A 2-deep pipeline model holds
// expected {ovf, result} values computed by an integer-arithmetic reference
// of the float-to-int rules; directed cases are also checked against constants.
module tb_ftoi;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op;
  logic        valid_in;
  logic        stall;
  logic [31:0] result;
  logic        valid_out;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  // Expected pipeline contents: stage 1 and output stage.
  logic        m_v1 = 1'b0;
  logic        m_v2 = 1'b0;
  logic [32:0] m_x1 = '0;
  logic [32:0] m_x2 = '0;

  always #5 clk = ~clk;

  ftoi dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .valid_in  (valid_in),
    .stall     (stall),
    .result    (result),
    .valid_out (valid_out),
    .ovf       (ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  // Reference conversion from the numeric rules; returns {ovf, result}.
  function automatic logic [32:0] ref_conv(input logic [31:0] o);
    int          e;
    longint      m;
    longint      mag;
    logic [31:0] r;
    e = int'(o[30:23]);
    m = longint'({1'b1, o[22:0]});
    if (o == 32'hCF00_0000) return {1'b0, 32'h8000_0000};
    if (e < 126) return 33'd0;
    if (e - 127 >= 31) return {1'b1, (o[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (e - 127 >= 23) begin
      mag = m << (e - 150);
    end else begin
      // floor(v + 0.5) == (floor(2v) + 1) / 2
      mag = ((m >> (149 - e)) + 1) >> 1;
    end
    r = mag[31:0];
    if (o[31]) r = -r;
    return {1'b0, r};
  endfunction

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic [31:0] o, input logic v, input logic s, input logic r);
    op       = o;
    valid_in = v;
    stall    = s;
    reset    = r;
    @(posedge clk);
    if (r) begin
      m_v1 = 1'b0;
      m_v2 = 1'b0;
      m_x1 = '0;
      m_x2 = '0;
    end else if (!s) begin
      m_v2 = m_v1;
      m_x2 = m_x1;
      m_v1 = v;
      m_x1 = ref_conv(o);
    end
    @(negedge clk);
    check_val("valid_out", {31'b0, valid_out}, {31'b0, m_v2});
    if (m_v2) begin
      check_val("result", result, m_x2[31:0]);
      check_val("ovf", {31'b0, ovf}, {31'b0, m_x2[32]});
    end
  endtask

  logic [31:0] d_op  [0:11];
  logic [31:0] d_res [0:11];
  logic        d_ovf [0:11];
  logic [31:0] s_op  [0:9];
  logic        s_v   [0:9];
  logic        s_st  [0:9];
  logic        e_v   [0:9];
  logic [31:0] e_r   [0:9];

  initial begin
    op       = '0;
    valid_in = 1'b0;
    stall    = 1'b0;
    reset    = 1'b1;

    d_op  = '{32'h3FC00000, 32'hC0200000, 32'h3F000000, 32'h3EFFFFFF,
              32'hBF000000, 32'h80000001, 32'h4EFFFFFF, 32'h4F000000,
              32'hCF000000, 32'hCF000001, 32'h7FC00000, 32'hBE99999A};
    d_res = '{32'h00000002, 32'hFFFFFFFD, 32'h00000001, 32'h00000000,
              32'hFFFFFFFF, 32'h00000000, 32'h7FFFFF80, 32'h7FFFFFFF,
              32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
    d_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    s_op = '{32'h3F800000, 32'h40000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
             32'h40400000, 32'h00000000, 32'h40800000, 32'h00000000, 32'h00000000};
    s_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    s_st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    e_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    e_r  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd0, 32'd4, 32'd0};

    @(negedge clk);
    cycle(32'h0, 1'b0, 1'b0, 1'b1);
    cycle(32'h0, 1'b0, 1'b0, 1'b1);
    check_val("rst_result", result, 32'h0);
    check_val("rst_ovf", {31'b0, ovf}, 32'h0);

    // Directed conversions: op at edge N, result visible after edge N+1.
    for (int i = 0; i < 12; i++) begin
      cycle(d_op[i], 1'b1, 1'b0, 1'b0);
      cycle(32'h0, 1'b0, 1'b0, 1'b0);
      check_val($sformatf("dir%0d_vld", i), {31'b0, valid_out}, 32'd1);
      check_val($sformatf("dir%0d_res", i), result, d_res[i]);
      check_val($sformatf("dir%0d_ovf", i), {31'b0, ovf}, {31'b0, d_ovf[i]});
    end

    // Stream 1.0..4.0 with a 3-cycle stall and one bubble.
    for (int i = 0; i < 10; i++) begin
      cycle(s_op[i], s_v[i], s_st[i], 1'b0);
      check_val($sformatf("strm%0d_vld", i), {31'b0, valid_out}, {31'b0, e_v[i]});
      if (e_v[i]) check_val($sformatf("strm%0d_res", i), result, e_r[i]);
    end

    // Reset with 5.0 / 6.0 in flight, then reset together with stall.
    cycle(32'h40A00000, 1'b1, 1'b0, 1'b0);
    cycle(32'h40C00000, 1'b1, 1'b0, 1'b0);
    cycle(32'h0, 1'b0, 1'b0, 1'b1);
    check_val("rif_vld", {31'b0, valid_out}, 32'd0);
    check_val("rif_res", result, 32'd0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_val("rif_vld2", {31'b0, valid_out}, 32'd0);
    cycle(32'h41000000, 1'b1, 1'b1, 1'b1);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_val("rst_stall_vld", {31'b0, valid_out}, 32'd0);
    cycle(32'h40E00000, 1'b1, 1'b0, 1'b0);
    check_val("rif_vld3", {31'b0, valid_out}, 32'd0);
    cycle(32'h0, 1'b0, 1'b0, 1'b0);
    check_val("rif_new_vld", {31'b0, valid_out}, 32'd1);
    check_val("rif_new_res", result, 32'd7);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 40000; i++) begin
      logic [31:0] o;
      logic [7:0]  ex;
      int          sel;
      sel = $urandom_range(0, 9);
      ex  = 8'($urandom_range(118, 160));
      o   = {1'($urandom), ex, 23'($urandom)};
      if (sel >= 6 && sel < 9) o = $urandom;
      if (sel == 9) begin
        case ($urandom_range(0, 5))
          0: o = 32'hCF000000;
          1: o = 32'h4F000000;
          2: o = 32'hBF000000;
          3: o = 32'h3F000000 | 32'($urandom_range(0, 1));
          4: o = 32'hFF800000;
          default: o = {1'($urandom), 8'd149, 23'h400000};
        endcase
      end
      cycle(o, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 999) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
